// File: rtl/piano_pkg.sv
// piano_pkg: shared constants for the piano front end.
//   NOTE_W           width of a note code
//   NOTE_NONE..SI    note codes (0 = no note, 1 = do ... 7 = si)
//   CLK_HZ           system clock frequency
//   DEBOUNCE_MS      debounce window in milliseconds
package piano_pkg;

    localparam int NOTE_W = 4;

    typedef logic [NOTE_W-1:0] note_t;

    localparam note_t NOTE_NONE = 4'd0;
    localparam note_t NOTE_DO   = 4'd1;
    localparam note_t NOTE_RE   = 4'd2;
    localparam note_t NOTE_MI   = 4'd3;
    localparam note_t NOTE_FA   = 4'd4;
    localparam note_t NOTE_SOL  = 4'd5;
    localparam note_t NOTE_LA   = 4'd6;
    localparam note_t NOTE_SI   = 4'd7;

    localparam int CLK_HZ      = 100000000;
    localparam int DEBOUNCE_MS = 20;

    // Stable cycles matching DEBOUNCE_MS at CLK_HZ (2,000,000 at 100 MHz).
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer followed by a stability counter for one key.
//   clk  system clock
//   rst  asynchronous active-high reset
//   raw  asynchronous key level, 1 = pressed
//   deb  debounced key level
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any sample agreeing with deb restarts the count, so only an
            // unbroken run of DEBOUNCE_CYCLES disagreeing samples flips deb.
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_input_encoder.sv
// key_input_encoder: debounces the note keys, priority-encodes them into a
// note code and registers the code together with press/release strobes.
//   clk             system clock
//   rst             asynchronous active-high reset
//   raw_keys        asynchronous key levels, 1 = pressed
//   enable          0 forces the note outputs to 0 (debouncers keep running)
//   pressed_key     current note code, 0 = none
//   key_held        1 while pressed_key != 0
//   key_pressed     one-cycle strobe on each new nonzero code
//   key_released    one-cycle strobe when the code returns to 0
//   debounced_keys  debounced key vector
module key_input_encoder
    import piano_pkg::*;
#(
    parameter int NUM_KEYS        = 7,
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] raw_keys,
    input  logic                enable,
    output logic [3:0]          pressed_key,
    output logic                key_held,
    output logic                key_pressed,
    output logic                key_released,
    output logic [NUM_KEYS-1:0] debounced_keys
);

    logic [NUM_KEYS-1:0] deb;
    note_t               code;
    logic                found;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk(clk),
            .rst(rst),
            .raw(raw_keys[g]),
            .deb(deb[g])
        );
    end

    assign debounced_keys = deb;

    // Lowest index wins: the first debounced key found locks the code.
    always_comb begin
        code  = NOTE_NONE;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (!found && deb[i]) begin
                code  = note_t'(i + 1);
                found = 1'b1;
            end
        end
        if (!enable) begin
            code = NOTE_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed_key  <= NOTE_NONE;
            key_held     <= 1'b0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
        end else begin
            pressed_key  <= code;
            key_held     <= (code != NOTE_NONE);
            key_pressed  <= (code != NOTE_NONE) && (code != pressed_key);
            key_released <= (code == NOTE_NONE) && (pressed_key != NOTE_NONE);
        end
    end

endmodule

// File: tb/tb_key_input_encoder.sv
// tb_key_input_encoder: scoreboard bench for key_input_encoder with a short
// debounce window. A reference model derives expected outputs from the raw
// sample history; a monitor compares them against the DUT every cycle.
module tb_key_input_encoder;

    localparam int NK = 7;
    localparam int DC = 4;

    typedef struct {
        int          pk;
        logic        held;
        logic        pr;
        logic        rl;
        logic [NK-1:0] deb;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [NK-1:0] raw_keys;
    logic          enable;
    logic [3:0]    pressed_key;
    logic          key_held;
    logic          key_pressed;
    logic          key_released;
    logic [NK-1:0] debounced_keys;

    int errors = 0;
    int checks = 0;
    int pcount = 0;
    int rcount = 0;

    exp_t          sb[$];
    logic [NK-1:0] hist[$];
    logic [NK-1:0] m_deb;
    int            m_pk;

    key_input_encoder #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .raw_keys(raw_keys),
        .enable(enable),
        .pressed_key(pressed_key),
        .key_held(key_held),
        .key_pressed(key_pressed),
        .key_released(key_released),
        .debounced_keys(debounced_keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Raw sample taken k edges ago; anything before reset counts as 0.
    function automatic logic [NK-1:0] samp(input int k);
        if (k >= hist.size()) return '0;
        return hist[hist.size() - 1 - k];
    endfunction

    // Reference model: a key's debounced level flips once the synchronized
    // level (raw delayed two edges) has disagreed with it for DC edges in a row.
    initial begin
        exp_t e;
        int   code;
        logic flip;
        m_deb = '0;
        m_pk  = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                hist.delete();
                m_deb = '0;
                m_pk  = 0;
                e = '{pk: 0, held: 1'b0, pr: 1'b0, rl: 1'b0, deb: '0};
            end else begin
                code = 0;
                if (enable) begin
                    for (int i = NK - 1; i >= 0; i--) if (m_deb[i]) code = i + 1;
                end
                e.pk   = code;
                e.held = (code != 0);
                e.pr   = (code != 0) && (code != m_pk);
                e.rl   = (code == 0) && (m_pk != 0);
                m_pk   = code;
                hist.push_back(raw_keys);
                if (hist.size() > 16) void'(hist.pop_front());
                for (int i = 0; i < NK; i++) begin
                    flip = 1'b1;
                    for (int k = 2; k <= DC + 1; k++) begin
                        logic [NK-1:0] s;
                        s = samp(k);
                        if (s[i] == m_deb[i]) flip = 1'b0;
                    end
                    if (flip) m_deb[i] = ~m_deb[i];
                end
                e.deb = m_deb;
            end
            sb.push_back(e);
        end
    end

    // Monitor: pops one expectation per output cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_pressed) pcount++;
            if (key_released) rcount++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pressed_key", int'(pressed_key), e.pk);
                check("key_held", int'(key_held), int'(e.held));
                check("key_pressed", int'(key_pressed), int'(e.pr));
                check("key_released", int'(key_released), int'(e.rl));
                check("debounced_keys", int'(debounced_keys), int'(e.deb));
                check("strobe_exclusive", int'(key_pressed && key_released), 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int p0, r0;
        rst      = 1'b1;
        raw_keys = '0;
        enable   = 1'b1;
        step(3);
        rst = 1'b0;
        step(6);

        // Single key press and release.
        raw_keys = 7'b0000100;
        step(20);
        raw_keys = '0;
        step(12);

        // Bouncing key 0 settles to one press.
        p0 = pcount; r0 = rcount;
        for (int b = 0; b < 4; b++) begin
            raw_keys = (b % 2 == 0) ? 7'b0000001 : 7'b0000000;
            step(2);
        end
        raw_keys = 7'b0000001;
        step(20);
        check("bounce_presses", pcount - p0, 1);
        check("bounce_releases", rcount - r0, 0);
        raw_keys = '0;
        step(12);

        // Overlapping keys: lower held, higher added, lower released.
        raw_keys = 7'b0000010;
        step(12);
        p0 = pcount;
        raw_keys = 7'b0100010;
        step(12);
        check("add_higher_no_strobe", pcount - p0, 0);
        check("add_higher_code", int'(pressed_key), 2);
        r0 = rcount;
        raw_keys = 7'b0100000;
        step(12);
        check("lower_release_code", int'(pressed_key), 6);
        check("lower_release_no_rel", rcount - r0, 0);
        raw_keys = '0;
        step(12);
        check("final_release", rcount - r0, 1);

        // Long hold gives a single strobe.
        p0 = pcount;
        raw_keys = 7'b0000100;
        step(200);
        check("hold200_presses", pcount - p0, 1);
        raw_keys = '0;
        step(12);

        // Enable toggled while key 4 held.
        raw_keys = 7'b0010000;
        step(12);
        enable = 1'b0;
        step(10);
        check("disabled_code", int'(pressed_key), 0);
        enable = 1'b1;
        step(10);
        check("reenabled_code", int'(pressed_key), 5);
        raw_keys = '0;
        step(12);

        // Reset pulsed mid-hold.
        raw_keys = 7'b0001000;
        step(12);
        rst = 1'b1;
        step(3);
        check("reset_code", int'(pressed_key), 0);
        check("reset_deb", int'(debounced_keys), 0);
        rst = 1'b0;
        step(20);
        raw_keys = '0;
        step(12);

        // Randomized phase.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) raw_keys = NK'($urandom);
            else raw_keys = raw_keys ^ (NK'(1) << $urandom_range(0, NK - 1));
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end
            step($urandom_range(1, 10));
        end
        enable   = 1'b1;
        raw_keys = '0;
        step(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/key_input_encoder.md
Name: key_input_encoder

Overview:
- Upstream front end for the piano's play and learning modes: converts the raw, bouncy note switches/buttons into one clean note code plus event strobes.
- Outputs pressed_key / key_pressed / key_held feed the learning-mode sequencer and free-play logic directly.
- key_pressed is a single-cycle strobe, so a held key can never advance a song more than once.

Parameters:
- NUM_KEYS, 7, number of note inputs; key i maps to note code i+1 (1=do ... 7=si); max 15.
- DEBOUNCE_CYCLES, 2000000, consecutive stable cycles required before a key change is accepted (20 ms at 100 MHz); must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- raw_keys  input  NUM_KEYS  asynchronous key levels, 1 = pressed.
- enable  input  1  0 forces all note outputs to 0; debouncers keep running.
- pressed_key  output  4  current note code, 0 = none.
- key_held  output  1  1 while pressed_key != 0.
- key_pressed  output  1  one-cycle strobe on each new nonzero code.
- key_released  output  1  one-cycle strobe when the code returns to 0.
- debounced_keys  output  NUM_KEYS  debounced key vector, for LEDs.

Behaviour:
- Reset values: all outputs 0; synchronizers, debounced bits and counters 0.
- Per key: 2-FF synchronizer (s1, s2), then a debouncer with a debounced bit deb and counter cnt of width clog2(DEBOUNCE_CYCLES)+1.
  - Each edge: if s2 == deb, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, deb <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count; deb never toggles.
- Encode: combinational priority encoder on deb, lowest index wins.
  - code = index+1, or 0 if no key is debounced high.
  - If enable = 0, code is forced to 0.
- Output register (one stage):
  - pressed_key <= code.
  - key_held <= (code != 0).
  - key_pressed <= (code != 0) && (code != pressed_key).
  - key_released <= (code == 0) && (pressed_key != 0).
- Latency: raw key first sampled high at edge N, held stable:
  - deb rises at edge N+1+DEBOUNCE_CYCLES.
  - pressed_key / key_pressed update at edge N+2+DEBOUNCE_CYCLES.
  - key_pressed is high for exactly one cycle.
  - Release has the same latency.
- Multiple keys: while a lower-index key is held, adding a higher key gives no event.
- Lower key released while a higher key is still held: code changes to the higher note and key_pressed strobes again; no key_released.
- Same key re-pressed: a new strobe only occurs after a debounced release (code passes through 0).
- enable falling while a key is held: key_released strobes once.
- enable rising while a key is held: key_pressed strobes once with the current code.
- Reset mid-operation clears all state. A key still held after reset deasserts is treated as a new press after full debounce latency.
- key_pressed and key_released are never high in the same cycle.

Decomposition:
- Shared package piano_pkg:
  - NOTE_NONE=0 and NOTE_DO..NOTE_SI=1..7 localparams.
  - Note code width 4.
  - CLK_HZ=100000000.
  - DEBOUNCE_MS=20.
- Sub-module key_debounce: synchronizer + counter for one bit, parameter DEBOUNCE_CYCLES. Generate NUM_KEYS instances.
- Encoder and output register live in the top.

Test Plan (DEBOUNCE_CYCLES=4):
- raw_keys=7'b0000100 rising before edge 10 and held -> pressed_key=3, key_pressed=1 only in the cycle after edge 16, key_held=1 thereafter; release -> key_released one-cycle pulse 6 cycles later, pressed_key=0.
- Key 0 bounces 1,0,1,0 every 2 cycles, then stable 1 -> exactly one key_pressed with code 1, issued 6 cycles after the last bounce edge; no key_released.
- Hold key 1 (code 2), then add key 5 -> no new strobe and pressed_key stays 2; release key 1 -> key_pressed strobe with pressed_key=6; release key 5 -> single key_released.
- Key 2 held for 200 cycles -> exactly one key_pressed strobe total.
- Key 4 held, enable driven 1->0->1 -> key_released when disabled, outputs 0 while disabled, key_pressed with code 5 on re-enable.
- Key held, rst pulsed for 3 cycles mid-hold -> all outputs 0 during reset; key_pressed re-occurs DEBOUNCE_CYCLES+2 edges after first post-reset sampling edge.
